// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo path: transform mode encodings, ASCII case
// bounds and the per-byte case transform used at FIFO push time.
package uart_pkg;

   typedef enum logic [1:0] {
      MODE_PASS  = 2'd0,
      MODE_UPPER = 2'd1,
      MODE_LOWER = 2'd2,
      MODE_SWAP  = 2'd3
   } mode_e;

   localparam logic [7:0] ASCII_UPPER_MIN = 8'h41;
   localparam logic [7:0] ASCII_UPPER_MAX = 8'h5A;
   localparam logic [7:0] ASCII_LOWER_MIN = 8'h61;
   localparam logic [7:0] ASCII_LOWER_MAX = 8'h7A;
   localparam logic [7:0] CASE_DELTA      = 8'h20;

   function automatic logic [7:0] xform_byte(input logic [1:0] mode, input logic [7:0] b);
      logic       is_upper;
      logic       is_lower;
      logic [7:0] r;
      is_upper = (b >= ASCII_UPPER_MIN) && (b <= ASCII_UPPER_MAX);
      is_lower = (b >= ASCII_LOWER_MIN) && (b <= ASCII_LOWER_MAX);
      r = b;
      case (mode_e'(mode))
         MODE_UPPER: if (is_lower) r = b - CASE_DELTA;
         MODE_LOWER: if (is_upper) r = b + CASE_DELTA;
         MODE_SWAP: begin
            if (is_lower) begin
               r = b - CASE_DELTA;
            end else if (is_upper) begin
               r = b + CASE_DELTA;
            end
         end
         default: r = b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and a combinational read of the head entry.
// The parent guarantees push only when not full and pop only when not empty.
module sync_fifo #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [DATA_W-1:0]      wdata,
   output logic [DATA_W-1:0]      rdata,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = 1;
   localparam logic [PTR_W:0]   LVL_ONE = 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [PTR_W:0]    level_q;

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({push, pop})
            2'b10:   level_q <= level_q + LVL_ONE;
            2'b01:   level_q <= level_q - LVL_ONE;
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= wdata;
   end

   assign rdata = mem[rd_ptr_q];
   assign level = level_q;

endmodule

// File: rtl/uart_echo_fifo.sv
// Echo path between UART receiver and transmitter: case transform applied at push time,
// buffered in a FIFO, with either backpressure or drop-and-count when full.
module uart_echo_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned DROP_ON_FULL = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             mode,
   input  logic [DATA_W-1:0]      s_data,
   input  logic                   s_valid,
   output logic                   s_ready,
   output logic [DATA_W-1:0]      m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic [15:0]            drop_cnt,
   output logic [DATA_W-1:0]      last_out
);

   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
   localparam bit DROP = (DROP_ON_FULL != 0);

   logic              full;
   logic              push;
   logic              pop;
   logic              drop;
   logic [DATA_W-1:0] wdata;
   logic [15:0]       drop_cnt_q;
   logic [DATA_W-1:0] last_out_q;

   // Gating with reset keeps both handshakes idle during the reset cycle itself.
   assign full    = (level == FULL_LVL);
   assign s_ready = !reset && (DROP || !full);
   assign m_valid = !reset && (level != '0);
   assign push    = !reset && s_valid && !full;
   assign drop    = DROP && !reset && s_valid && full;
   assign pop     = m_valid && m_ready;

   always_comb begin
      wdata      = s_data;
      wdata[7:0] = xform_byte(mode, s_data[7:0]);
   end

   sync_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .push (push),
      .pop  (pop),
      .wdata(wdata),
      .rdata(m_data),
      .level(level)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt_q <= '0;
         last_out_q <= '0;
      end else begin
         if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
         if (pop) last_out_q <= m_data;
      end
   end

   assign drop_cnt = drop_cnt_q;
   assign last_out = last_out_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Two DEPTH=4 instances (backpressure and drop-on-full) driven by directed and random
// traffic, each checked every cycle against a queue-based reference model.
module tb_uart_echo_fifo;

   localparam int unsigned DW    = 10;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned LW    = 3;

   logic          clk;
   logic          reset;
   logic [1:0]    mode;
   logic [DW-1:0] s_data [2];
   logic [1:0]    s_valid;
   logic [1:0]    m_ready;
   logic [1:0]    s_ready_w;
   logic [1:0]    m_valid_w;
   logic [DW-1:0] m_data_w [2];
   logic [DW-1:0] last_w [2];
   logic [LW-1:0] level_w [2];
   logic [15:0]   drop_w [2];

   int n_vec = 0;
   int n_err = 0;
   bit started = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference transform written straight from the ASCII rules.
   function automatic logic [DW-1:0] ref_xform(input logic [1:0] md, input logic [DW-1:0] w);
      logic [7:0] c;
      c = w[7:0];
      if ((md == 2'd1 || md == 2'd3) && c >= "a" && c <= "z") c = c - 8'd32;
      else if ((md == 2'd2 || md == 2'd3) && c >= "A" && c <= "Z") c = c + 8'd32;
      return {w[DW-1:8], c};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [DW-1:0] mq [$];
      int unsigned   dcnt = 0;
      logic [DW-1:0] last_m = '0;

      uart_echo_fifo #(
         .DATA_W      (DW),
         .DEPTH       (DEPTH),
         .DROP_ON_FULL(g)
      ) u_dut (
         .clk     (clk),
         .reset   (reset),
         .mode    (mode),
         .s_data  (s_data[g]),
         .s_valid (s_valid[g]),
         .s_ready (s_ready_w[g]),
         .m_data  (m_data_w[g]),
         .m_valid (m_valid_w[g]),
         .m_ready (m_ready[g]),
         .level   (level_w[g]),
         .drop_cnt(drop_w[g]),
         .last_out(last_w[g])
      );

      // Model: contents of the FIFO as a queue, updated on each rising edge.
      always @(posedge clk) begin
         bit was_full;
         if (reset) begin
            mq.delete();
            dcnt   = 0;
            last_m = '0;
         end else begin
            was_full = (mq.size() == DEPTH);
            if (mq.size() != 0 && m_ready[g]) last_m = mq.pop_front();
            if (s_valid[g] && !was_full) mq.push_back(ref_xform(mode, s_data[g]));
            if (g == 1 && s_valid[g] && was_full && dcnt < 65535) dcnt++;
         end
      end

      // Monitor: compare every output against the model away from the active edge.
      always @(negedge clk) begin
         if (started) begin
            chk($sformatf("dut%0d.m_valid", g), 32'(m_valid_w[g]), 32'(!reset && mq.size() != 0));
            chk($sformatf("dut%0d.s_ready", g), 32'(s_ready_w[g]),
                32'(!reset && (g == 1 || mq.size() < DEPTH)));
            chk($sformatf("dut%0d.level", g), 32'(level_w[g]), 32'(mq.size()));
            chk($sformatf("dut%0d.drop_cnt", g), 32'(drop_w[g]), dcnt);
            chk($sformatf("dut%0d.last_out", g), 32'(last_w[g]), 32'(last_m));
            if (m_valid_w[g] && mq.size() != 0)
               chk($sformatf("dut%0d.m_data", g), 32'(m_data_w[g]), 32'(mq[0]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold a word on the sink until the DUT accepts it or the budget runs out.
   task automatic offer(input int g, input logic [DW-1:0] w);
      bit ok;
      ok         = 1'b0;
      s_data[g]  = w;
      s_valid[g] = 1'b1;
      for (int n = 0; n < 20 && !ok; n++) begin
         @(negedge clk);
         ok = s_ready_w[g];
         tick();
      end
      s_valid[g] = 1'b0;
      if (!ok) begin
         n_vec++;
         n_err++;
         $display("FAIL dut%0d.offer_timeout: got no s_ready expected s_ready within 20", g);
      end
   endtask

   task automatic drain();
      s_valid = 2'b00;
      m_ready = 2'b11;
      repeat (8) tick();
   endtask

   initial begin
      logic [DW-1:0] w3 [3];
      logic [DW-1:0] e3 [3];
      reset   = 1'b1;
      mode    = 2'd0;
      s_valid = 2'b00;
      m_ready = 2'b00;
      s_data[0] = '0;
      s_data[1] = '0;
      tick();
      started = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // Upper mode, back-to-back pushes with the sink always ready.
      w3 = '{10'h061, 10'h05A, 10'h035};
      e3 = '{10'h041, 10'h05A, 10'h035};
      mode    = 2'd1;
      m_ready = 2'b11;
      for (int k = 0; k < 3; k++) begin
         s_valid   = 2'b11;
         s_data[0] = w3[k];
         s_data[1] = w3[k];
         @(negedge clk);
         if (k > 0) begin
            chk("upper.m_valid", 32'(m_valid_w[0]), 32'd1);
            chk("upper.m_data", 32'(m_data_w[0]), 32'(e3[k-1]));
         end
         tick();
      end
      s_valid = 2'b00;
      @(negedge clk);
      chk("upper.m_data_last", 32'(m_data_w[1]), 32'(e3[2]));
      drain();

      // Swapcase sampled at push; mode change while queued must not alter output.
      mode    = 2'd3;
      m_ready = 2'b00;
      s_valid = 2'b11;
      s_data[0] = 10'h061;
      s_data[1] = 10'h061;
      tick();
      s_data[0] = 10'h042;
      s_data[1] = 10'h042;
      tick();
      s_valid = 2'b00;
      mode    = 2'd0;
      tick();
      @(negedge clk);
      chk("swap.m_data0", 32'(m_data_w[0]), 32'h041);
      tick();
      m_ready = 2'b11;
      tick();
      @(negedge clk);
      chk("swap.m_data1", 32'(m_data_w[0]), 32'h062);
      drain();

      // Backpressure instance: fill, stall, then release; all six words must emerge.
      m_ready = 2'b00;
      for (int i = 0; i < 4; i++) offer(0, DW'(10'h300 + i));
      s_data[0]  = 10'h304;
      s_valid[0] = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      chk("bp.s_ready_full", 32'(s_ready_w[0]), 32'd0);
      chk("bp.level_full", 32'(level_w[0]), 32'd4);
      tick();
      m_ready[0] = 1'b1;
      offer(0, 10'h304);
      offer(0, 10'h305);
      drain();

      // Backpressure instance: full with push and pop together refuses the push.
      m_ready = 2'b00;
      for (int i = 0; i < 4; i++) offer(0, DW'(10'h1C0 + i));
      s_data[0]  = 10'h1C9;
      s_valid[0] = 1'b1;
      m_ready[0] = 1'b1;
      @(negedge clk);
      chk("bp.s_ready_pushpop", 32'(s_ready_w[0]), 32'd0);
      tick();
      s_valid[0] = 1'b0;
      m_ready[0] = 1'b0;
      @(negedge clk);
      chk("bp.level_pushpop", 32'(level_w[0]), 32'd3);
      drain();

      // Drop instance: six words into a stalled FIFO keep the first four.
      m_ready = 2'b00;
      for (int i = 0; i < 6; i++) begin
         s_valid[1] = 1'b1;
         s_data[1]  = DW'(10'h280 + i);
         tick();
      end
      s_valid[1] = 1'b0;
      @(negedge clk);
      chk("drop.level", 32'(level_w[1]), 32'd4);
      chk("drop.drop_cnt", 32'(drop_w[1]), 32'd2);
      tick();
      // Full with simultaneous push and pop: the push is dropped.
      s_valid[1] = 1'b1;
      s_data[1]  = 10'h2FF;
      m_ready[1] = 1'b1;
      tick();
      s_valid[1] = 1'b0;
      m_ready[1] = 1'b0;
      @(negedge clk);
      chk("drop.level_pushpop", 32'(level_w[1]), 32'd3);
      chk("drop.cnt_pushpop", 32'(drop_w[1]), 32'd3);
      drain();

      // One-cycle reset with three words queued discards them all.
      m_ready = 2'b00;
      s_valid = 2'b11;
      for (int i = 0; i < 3; i++) begin
         s_data[0] = DW'(10'h0A0 + i);
         s_data[1] = DW'(10'h0B0 + i);
         tick();
      end
      s_valid = 2'b00;
      reset   = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk("rst.level", 32'(level_w[g]), 32'd0);
         chk("rst.m_valid", 32'(m_valid_w[g]), 32'd0);
         chk("rst.drop_cnt", 32'(drop_w[g]), 32'd0);
      end
      m_ready = 2'b11;
      repeat (6) tick();

      // Random traffic with occasional reset pulses.
      for (int c = 0; c < 3000; c++) begin
         mode  = 2'($urandom_range(0, 3));
         reset = ($urandom_range(0, 199) == 0);
         for (int g = 0; g < 2; g++) begin
            logic [7:0] b;
            s_valid[g] = ($urandom_range(0, 99) < 60);
            m_ready[g] = ($urandom_range(0, 99) < 45);
            case ($urandom_range(0, 2))
               0:       b = 8'(8'h3F + $urandom_range(0, 29));
               1:       b = 8'(8'h5F + $urandom_range(0, 29));
               default: b = 8'($urandom);
            endcase
            s_data[g] = {2'($urandom), b};
         end
         tick();
      end
      reset = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
